// File: rtl/render_sequencer.sv
// render_sequencer: owns the VGA pixel port; clears the frame, then runs renderer 0 and 1 in turn (optional clipping via RENDER_SEQ_CLIP_EN)
module render_sequencer #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        skip_clear,
   input  logic [2:0]  bg_colour,
   output logic        c0_start,
   output logic        c1_start,
   input  logic        c0_done,
   input  logic        c1_done,
   input  logic [7:0]  c0_x,
   input  logic [7:0]  c1_x,
   input  logic [6:0]  c0_y,
   input  logic [6:0]  c1_y,
   input  logic [2:0]  c0_colour,
   input  logic [2:0]  c1_colour,
   input  logic        c0_plot,
   input  logic        c1_plot,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot,
   output logic        busy,
   output logic        done,
   output logic [15:0] clip_count
);
   typedef enum logic [2:0] {IDLE, CLEAR, RUN0, REL0, RUN1, REL1, DONE} state_t;
   localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
   localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
   state_t state;
   logic [7:0] fx, sx;
   logic [6:0] fy, sy;
   logic [2:0] sc;
   logic sel0, sel1, clr, act, sp, keep;
`ifdef RENDER_SEQ_CLIP_EN
   logic oob;
`endif
   assign c0_start = state == RUN0;
   assign c1_start = state == RUN1;
   assign busy = state != IDLE && state != DONE;
   assign done = state == DONE;
   // select the active renderer and decide whether its plot reaches the adapter
   always_comb begin
      sel0 = state == RUN0;
      sel1 = state == RUN1;
      clr = state == CLEAR;
      act = go & (clr | sel0 | sel1);
      sx = sel1 ? c1_x : sel0 ? c0_x : '0;
      sy = sel1 ? c1_y : sel0 ? c0_y : '0;
      sc = sel1 ? c1_colour : sel0 ? c0_colour : '0;
      sp = (sel0 & c0_plot) | (sel1 & c1_plot);
`ifdef RENDER_SEQ_CLIP_EN
      oob = sx > X_LAST || sy > Y_LAST;
      keep = sp & ~oob;
`else
      keep = sp;
`endif
   end
   // sequencer state, raster fill counters and clip counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         fx <= '0;
         fy <= '0;
         clip_count <= '0;
      end else begin
         case (state)
            IDLE: if (go) begin
               fx <= '0;
               fy <= '0;
               clip_count <= '0;
               state <= skip_clear ? RUN0 : CLEAR;
            end
            CLEAR: if (!go) state <= IDLE;
               else if (fx == X_LAST) begin
                  fx <= '0;
                  if (fy == Y_LAST) state <= RUN0;
                  else fy <= fy + 7'd1;
               end else fx <= fx + 8'd1;
            RUN0: state <= !go ? IDLE : c0_done ? REL0 : RUN0;
            REL0: state <= go ? RUN1 : IDLE;
            RUN1: state <= !go ? IDLE : c1_done ? REL1 : RUN1;
            REL1: state <= go ? DONE : IDLE;
            DONE: state <= go ? DONE : IDLE;
            default: state <= IDLE;
         endcase
`ifdef RENDER_SEQ_CLIP_EN
         if (go && sp && oob && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
`endif
      end
   end
   // registered adapter port: fill pixel in CLEAR, active renderer in RUN0/RUN1, idle otherwise or on abort
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_x <= '0;
         vga_y <= '0;
         vga_colour <= '0;
         vga_plot <= 1'b0;
      end else begin
         vga_x <= !act ? '0 : clr ? fx : sx;
         vga_y <= !act ? '0 : clr ? fy : sy;
         vga_colour <= !act ? '0 : clr ? bg_colour : sc;
         vga_plot <= act & (clr | keep);
      end
   end
endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer: directed self-checking bench for render_sequencer
module tb_render_sequencer;
`ifdef RENDER_SEQ_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif
   logic clk = 0, rst = 1, go = 0, skip_clear = 0;
   logic [2:0] bg_colour = 0, c0_colour = 0, c1_colour = 0;
   logic c0_start, c1_start, c0_done = 0, c1_done = 0, c0_plot = 0, c1_plot = 0;
   logic [7:0] c0_x = 0, c1_x = 0, vga_x;
   logic [6:0] c0_y = 0, c1_y = 0, vga_y;
   logic [2:0] vga_colour;
   logic vga_plot, busy, done;
   logic [15:0] clip_count;
   int checks = 0, errors = 0, bad, plots;

   render_sequencer dut (
      .clk(clk), .rst(rst), .go(go), .skip_clear(skip_clear), .bg_colour(bg_colour),
      .c0_start(c0_start), .c1_start(c1_start), .c0_done(c0_done), .c1_done(c1_done),
      .c0_x(c0_x), .c1_x(c1_x), .c0_y(c0_y), .c1_y(c1_y),
      .c0_colour(c0_colour), .c1_colour(c1_colour), .c0_plot(c0_plot), .c1_plot(c1_plot),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .busy(busy), .done(done), .clip_count(clip_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_plot", vga_plot, 0);
      chk("rst_c0_start", c0_start, 0);
      chk("rst_done", done, 0);
      chk("rst_clip", clip_count, 0);
      tick();
      rst = 0;
      tick();
      // full clear with colour 0
      go = 1;
      skip_clear = 0;
      bg_colour = 3'b000;
      tick();
      chk("clear_busy", busy, 1);
      chk("clear_first_plot_latency", vga_plot, 0);
      bad = 0;
      for (int i = 0; i < 19200; i++) begin
         tick();
         if (vga_plot !== 1'b1 || vga_x !== 8'(i % 160) || vga_y !== 7'(i / 160) || vga_colour !== 3'b000) bad++;
         if (i == 0) begin
            chk("clear_first_x", vga_x, 0);
            chk("clear_first_y", vga_y, 0);
         end
         if (i < 19199 && c0_start !== 1'b0) bad++;
      end
      chk("clear_raster_bad", bad, 0);
      chk("clear_last_x", vga_x, 159);
      chk("clear_last_y", vga_y, 119);
      chk("clear_c0_start", c0_start, 1);
      // routing in RUN0
      c1_plot = 1; c1_x = 10; c1_y = 10; c1_colour = 3'd7;
      tick();
      chk("inactive_c1_plot", vga_plot, 0);
      c1_plot = 0;
      c0_plot = 1; c0_x = 80; c0_y = 60; c0_colour = 3'd5;
      tick();
      chk("c0_route_plot", vga_plot, 1);
      chk("c0_route_x", vga_x, 80);
      chk("c0_route_y", vga_y, 60);
      chk("c0_route_colour", vga_colour, 5);
      c0_plot = 0;
      go = 0;
      tick();
      chk("abort_run0_start", c0_start, 0);
      chk("abort_run0_busy", busy, 0);
      chk("abort_run0_done", done, 0);
      // minimum sequence with skip_clear
      go = 1;
      skip_clear = 1;
      tick();
      chk("seq_c0_start", c0_start, 1);
      tick();
      c0_done = 1;
      tick();
      chk("seq_rel0_start", c0_start, 0);
      chk("seq_rel0_busy", busy, 1);
      c0_done = 0;
      tick();
      chk("seq_c1_start", c1_start, 1);
      tick();
      c1_done = 1;
      tick();
      chk("seq_rel1_start", c1_start, 0);
      chk("seq_done_early", done, 0);
      c1_done = 0;
      tick();
      chk("seq_done_cycle7", done, 1);
      chk("seq_done_busy", busy, 0);
      tick();
      chk("seq_done_held", done, 1);
      go = 0;
      tick();
      chk("seq_done_release", done, 0);
      // clipping
      go = 1;
      tick();
      plots = 0;
      c0_plot = 1; c0_x = 159; c0_y = 119; c0_colour = 3'd2;
      tick();
      plots += vga_plot;
      chk("clip_in_range", vga_plot, 1);
      c0_x = 160; c0_y = 0;
      tick();
      plots += vga_plot;
      chk("clip_x160", vga_plot, !CLIP);
      c0_x = 0; c0_y = 120;
      tick();
      plots += vga_plot;
      chk("clip_y120", vga_plot, !CLIP);
      c0_plot = 0;
      tick();
      chk("clip_plots", plots, CLIP ? 1 : 3);
      chk("clip_count", clip_count, CLIP ? 2 : 0);
      go = 0;
      tick();
      // abort in the middle of CLEAR
      go = 1;
      skip_clear = 0;
      bg_colour = 3'b110;
      tick();
      for (int i = 0; i <= 5000; i++) tick();
      chk("mid_clear_x", vga_x, 40);
      chk("mid_clear_y", vga_y, 31);
      chk("mid_clear_plot", vga_plot, 1);
      go = 0;
      tick();
      chk("abort_clear_plot", vga_plot, 0);
      chk("abort_clear_busy", busy, 0);
      go = 1;
      tick();
      tick();
      chk("restart_plot", vga_plot, 1);
      chk("restart_x", vga_x, 0);
      chk("restart_y", vga_y, 0);
      chk("restart_colour", vga_colour, 6);
      chk("restart_clip_cleared", clip_count, 0);
      go = 0;
      tick();
      // async reset during RUN1
      go = 1;
      skip_clear = 1;
      tick();
      c0_done = 1;
      tick();
      c0_done = 0;
      tick();
      chk("run1_start", c1_start, 1);
      c1_plot = 1; c1_x = 200; c1_y = 5; c1_colour = 3'd1;
      tick();
      c1_x = 3; c1_y = 4;
      tick();
      chk("run1_plot", vga_plot, 1);
      chk("run1_clip", clip_count, CLIP ? 1 : 0);
      #2;
      rst = 1;
      #1;
      chk("async_c1_start", c1_start, 0);
      chk("async_plot", vga_plot, 0);
      chk("async_busy", busy, 0);
      chk("async_clip", clip_count, 0);
      c1_plot = 0;
      go = 0;
      tick();
      rst = 0;
      tick();
      chk("post_rst_idle", busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
